// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN dot-product sequencer.
//   state_t     : sequencer FSM states
//   CNN_OPCODE  : major opcode of the custom CNN instruction
//   CNN_ALUOP   : ALUOp encoding that selects the sequencer
//   WORD_STRIDE : byte distance between consecutive 32-bit elements
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_A,
    S_WAIT_A,
    S_REQ_B,
    S_WAIT_B,
    S_WB
  } state_t;

  localparam logic [6:0]  CNN_OPCODE  = 7'b0101011;
  localparam logic [1:0]  CNN_ALUOP   = 2'b11;
  localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/cnn_mac_unit.sv
// Signed multiply-accumulate register.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : zero the accumulator (takes priority over en)
//   en        : acc <= acc + low XLEN bits of signed a*b (wrapping)
//   a, b      : operands
//   acc       : current accumulator value
//   acc_next  : value acc would take if en were asserted this cycle
module cnn_mac_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            en,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] acc,
  output logic [XLEN-1:0] acc_next
);

  logic [XLEN-1:0] prod;

  // Low XLEN bits of a signed product equal those of the unsigned one;
  // signed operands keep the intent explicit.
  assign prod     = XLEN'($signed(a) * $signed(b));
  assign acc_next = acc + prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/cnn_dot_sequencer.sv
// Multi-cycle sequencer for the custom CNN dot-product instruction.
// Fetches len activation/weight pairs over a single-outstanding read port,
// multiply-accumulates them and presents one result for writeback.
//   clk, rst         : clock, asynchronous active-high reset
//   start            : custom op in execute (sampled only in IDLE)
//   op_len           : element-pair count (clamped to MAX_LEN)
//   op_src_a/op_src_b: activation / weight base addresses
//   op_rd            : destination register
//   busy             : pipeline stall (combinational, includes start cycle)
//   mem_req/mem_addr : read request and address, held until mem_gnt
//   mem_gnt          : request accepted
//   mem_rvalid/rdata : read response
//   wb_valid/rd/data : result, held until wb_ready
//   wb_ready         : writeback accepted
module cnn_dot_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] op_len,
  input  logic [XLEN-1:0]  op_src_a,
  input  logic [XLEN-1:0]  op_src_b,
  input  logic [4:0]       op_rd,
  output logic             busy,
  output logic             mem_req,
  output logic [XLEN-1:0]  mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  input  logic             wb_ready
);

  state_t           state;
  logic [XLEN-1:0]  src_a;
  logic [XLEN-1:0]  src_b;
  logic [4:0]       rd;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  logic [XLEN-1:0]  a_reg;

  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] idx_inc;
  logic             mac_clear;
  logic             mac_en;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  acc_next;

  function automatic logic [XLEN-1:0] elem_addr(input logic [XLEN-1:0]  base,
                                                input logic [LEN_W-1:0] i);
    return base + XLEN'(i) * XLEN'(WORD_STRIDE);
  endfunction

  assign len_clamped = (op_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : op_len;
  assign idx_inc     = idx + LEN_W'(1);
  assign busy        = (state == S_IDLE) ? start : 1'b1;
  assign mac_clear   = (state == S_IDLE) && start;
  assign mac_en      = (state == S_WAIT_B) && mem_rvalid;

  cnn_mac_unit #(.XLEN(XLEN)) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear    (mac_clear),
    .en       (mac_en),
    .a        (a_reg),
    .b        (mem_rdata),
    .acc      (acc),
    .acc_next (acc_next)
  );

  // mem_req/mem_addr and wb_* are registered: each transition that enters a
  // REQ or WB state loads them so they are already valid in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      src_a    <= '0;
      src_b    <= '0;
      rd       <= '0;
      len      <= '0;
      idx      <= '0;
      a_reg    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            src_a <= op_src_a;
            src_b <= op_src_b;
            rd    <= op_rd;
            len   <= len_clamped;
            idx   <= '0;
            if (len_clamped == '0) begin
              wb_valid <= 1'b1;
              wb_rd    <= op_rd;
              wb_data  <= '0;
              state    <= S_WB;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= op_src_a;
              state    <= S_REQ_A;
            end
          end
        end
        S_REQ_A: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_WAIT_A;
          end
        end
        S_WAIT_A: begin
          if (mem_rvalid) begin
            a_reg    <= mem_rdata;
            mem_req  <= 1'b1;
            mem_addr <= elem_addr(src_b, idx);
            state    <= S_REQ_B;
          end
        end
        S_REQ_B: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (mem_rvalid) begin
            idx <= idx_inc;
            if (idx_inc == len) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd;
              wb_data  <= acc_next;
              state    <= S_WB;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= elem_addr(src_a, idx_inc);
              state    <= S_REQ_A;
            end
          end
        end
        S_WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_dot_sequencer.sv
module tb_cnn_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  op_len = '0;
  logic [31:0] op_src_a = '0;
  logic [31:0] op_src_b = '0;
  logic [4:0]  op_rd = '0;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready = 1'b1;

  logic        gnt_block = 1'b0;
  logic        stray_rv  = 1'b0;
  logic        rv_q = 1'b0;
  logic [31:0] rd_q = '0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] addr_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  cnn_dot_sequencer #(.XLEN(32), .MAX_LEN(16), .LEN_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_len     (op_len),
    .op_src_a   (op_src_a),
    .op_src_b   (op_src_b),
    .op_rd      (op_rd),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready)
  );

  // Zero-wait memory: grant in the request cycle, data the next cycle.
  assign mem_gnt    = mem_req & ~gnt_block;
  assign mem_rvalid = rv_q | stray_rv;
  assign mem_rdata  = stray_rv ? 32'h0000_0077 : rd_q;

  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      addr_q.push_back(mem_addr);
      rv_q <= 1'b1;
      rd_q <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
    end else begin
      rv_q <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] len, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rdx);
    @(negedge clk);
    start = 1'b1; op_len = len; op_src_a = a; op_src_b = b; op_rd = rdx;
    #1 check("busy_in_start_cycle", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Issue one op and run until busy drops; records result and cycle count.
  task automatic run_op(input logic [4:0] len, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rdx, output int cycles, output int wb_cnt,
                        output logic [31:0] data, output logic [4:0] rdo);
    addr_q.delete();
    wb_cnt = 0; data = 'x; rdo = 'x;
    issue(len, a, b, rdx);
    cycles = 1;
    while (busy && cycles < 200) begin
      if (wb_valid) begin
        wb_cnt++; data = wb_data; rdo = wb_rd;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    int cyc, wbn;
    logic [31:0] d;
    logic [4:0] r;

    mem[32'h100] = 32'd1; mem[32'h104] = 32'd2; mem[32'h108] = 32'd3;
    mem[32'h200] = 32'd4; mem[32'h204] = 32'd5; mem[32'h208] = 32'd6;
    mem[32'h300] = 32'd3; mem[32'h304] = 32'hFFFF_FFFF;
    mem[32'h400] = 32'd5; mem[32'h404] = 32'd2;
    mem[32'h500] = 32'hFFFF_FFFE; mem[32'h600] = 32'd7;
    mem[32'h700] = 32'h4000_0000; mem[32'h800] = 32'd4;
    mem[32'h900] = 32'd6; mem[32'hA00] = 32'hFFFF_FFFD;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    @(negedge clk); rst = 1'b0;

    // len=3 dot product: 1*4+2*5+3*6 = 32
    run_op(5'd3, 32'h100, 32'h200, 5'd9, cyc, wbn, d, r);
    check("dot3_cycles", 32'(cyc), 32'd14);
    check("dot3_wb_count", 32'(wbn), 32'd1);
    check("dot3_data", d, 32'd32);
    check("dot3_rd", 32'(r), 32'd9);
    check("dot3_nreq", 32'(addr_q.size()), 32'd6);
    if (addr_q.size() == 6) begin
      check("dot3_addr0", addr_q[0], 32'h100);
      check("dot3_addr1", addr_q[1], 32'h200);
      check("dot3_addr2", addr_q[2], 32'h104);
      check("dot3_addr3", addr_q[3], 32'h204);
      check("dot3_addr4", addr_q[4], 32'h108);
      check("dot3_addr5", addr_q[5], 32'h208);
    end

    // len=0: no memory traffic, zero result in the second cycle
    run_op(5'd0, 32'h100, 32'h200, 5'd3, cyc, wbn, d, r);
    check("len0_cycles", 32'(cyc), 32'd2);
    check("len0_wb_count", 32'(wbn), 32'd1);
    check("len0_data", d, 32'd0);
    check("len0_rd", 32'(r), 32'd3);
    check("len0_nreq", 32'(addr_q.size()), 32'd0);

    // Grant withheld 3 cycles on first request: 3*5 + (-1)*2 = 13
    addr_q.delete();
    gnt_block = 1'b1;
    issue(5'd2, 32'h300, 32'h400, 5'd7);
    for (int i = 0; i < 3; i++) begin
      check("stall_req", 32'(mem_req), 32'd1);
      check("stall_addr", mem_addr, 32'h300);
      if (i < 2) @(negedge clk);
    end
    gnt_block = 1'b0;
    cyc = 0; wbn = 0; d = 'x;
    while (busy && cyc < 200) begin
      if (wb_valid) begin wbn++; d = wb_data; end
      @(negedge clk);
      cyc++;
    end
    check("stall_wb_count", 32'(wbn), 32'd1);
    check("stall_data", d, 32'd13);
    check("stall_nreq", 32'(addr_q.size()), 32'd4);

    // Signed and wrapping products
    run_op(5'd1, 32'h500, 32'h600, 5'd1, cyc, wbn, d, r);
    check("neg_data", d, 32'hFFFF_FFF2);
    check("neg_cycles", 32'(cyc), 32'd6);
    run_op(5'd1, 32'h700, 32'h800, 5'd2, cyc, wbn, d, r);
    check("wrap_data", d, 32'h0000_0000);

    // Oversized length is clamped to 16 element pairs
    run_op(5'd31, 32'h1000, 32'h2000, 5'd4, cyc, wbn, d, r);
    check("clamp_nreq", 32'(addr_q.size()), 32'd32);
    check("clamp_cycles", 32'(cyc), 32'd66);

    // start during WAIT_B ignored; wb held while wb_ready low: 6*(-3) = -18
    issue(5'd1, 32'h900, 32'hA00, 5'd11);
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) start = 1'b1;
      if (i == 5) start = 1'b0;
      if (i == 4) wb_ready = 1'b0;
      #1;
      if (i <= 6) check("hold_busy", 32'(busy), 32'd1);
      if (i == 5 || i == 6) begin
        check("hold_valid", 32'(wb_valid), 32'd1);
        check("hold_data", wb_data, 32'hFFFF_FFEE);
        check("hold_rd", 32'(wb_rd), 32'd11);
      end
      if (i == 6) wb_ready = 1'b1;
      if (i >= 7) begin
        check("hold_after_valid", 32'(wb_valid), 32'd0);
        check("hold_after_busy", 32'(busy), 32'd0);
      end
      @(negedge clk);
    end

    // Reset in WAIT_A, then a stray rvalid
    issue(5'd2, 32'h100, 32'h200, 5'd5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_wb_data", wb_data, 32'd0);
    check("arst_wb_valid", 32'(wb_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray_rv = 1'b1;
    @(negedge clk);
    stray_rv = 1'b0;
    wbn = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid || busy || mem_req) wbn++;
      @(negedge clk);
    end
    check("arst_idle_quiet", 32'(wbn), 32'd0);
    run_op(5'd3, 32'h100, 32'h200, 5'd6, cyc, wbn, d, r);
    check("post_rst_data", d, 32'd32);
    check("post_rst_rd", 32'(r), 32'd6);
    check("post_rst_cycles", 32'(cyc), 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cnn_dot_sequencer.md
Name: cnn_dot_sequencer

Overview:
- Multi-cycle sequencer for the custom CNN instruction (opcode 7'b0101011, ALUOp 2'b11).
- On start, it fetches N activation/weight word pairs from data memory, multiply-accumulates them, and returns one 32-bit result for register rd.
- Sits beside the execute stage. Drives the pipeline stall (busy) and owns a single-outstanding-request data-memory port.

Parameters:
- XLEN, 32, data/address width
- MAX_LEN, 16, maximum element pairs per instruction; larger requests are clamped
- LEN_W, 5, width of op_len

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  custom op present in execute; sampled only in IDLE
- op_len  in  LEN_W  element-pair count
- op_src_a  in  XLEN  activation base address (rs1)
- op_src_b  in  XLEN  weight base address (rs2)
- op_rd  in  5  destination register
- busy  out  1  pipeline stall
- mem_req  out  1  read request
- mem_addr  out  XLEN  read address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read data
- wb_valid  out  1  result valid
- wb_rd  out  5  result register
- wb_data  out  XLEN  result
- wb_ready  in  1  writeback accepted

Behaviour:
- Reset (async, rst=1): state=IDLE. mem_req, wb_valid, wb_data, wb_rd, mem_addr and all internal counters/accumulator are 0. Reset mid-operation abandons the operation; a later mem_rvalid is ignored.
- busy = start (in IDLE) | (state != IDLE), combinational, so the pipeline stalls in the start cycle.
- States: IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, WB.
- IDLE:
  - On start, latch op_src_a, op_src_b, op_rd and len = min(op_len, MAX_LEN); clear acc and idx.
  - len==0 -> WB with acc=0; otherwise -> REQ_A.
- REQ_A:
  - mem_req=1, mem_addr = src_a + 4*idx (mod 2^XLEN).
  - Hold req/addr stable until mem_gnt. On gnt -> WAIT_A.
- WAIT_A: on mem_rvalid, capture a=mem_rdata -> REQ_B.
- REQ_B: as REQ_A, with mem_addr = src_b + 4*idx.
- WAIT_B:
  - On mem_rvalid: acc <= acc + low XLEN bits of (a * mem_rdata), signed two's complement, wrapping; idx++.
  - idx+1==len -> WB; otherwise -> REQ_A.
- WB:
  - wb_valid=1, wb_rd=rd, wb_data=acc, held stable until wb_ready.
  - On wb_valid&wb_ready -> IDLE; wb_valid drops next cycle.
- mem_rvalid outside the WAIT states is ignored. Data may return the cycle after gnt at the earliest.
- start while state != IDLE is ignored; no queueing.
- Latency with zero-wait memory (gnt same cycle, rvalid next cycle) and wb_ready=1: 1 + 4*len + 1 cycles from start to IDLE.
- Back-to-back: start is accepted in the first IDLE cycle after WB.

Decomposition:
- Shared package cnn_pkg:
  - state enum
  - CNN_OPCODE=7'b0101011
  - CNN_ALUOP=2'b11
  - word stride constant 4
- One natural sub-module: cnn_mac_unit, which holds the accumulator and does signed multiply + wrapping add, with clear and enable inputs.

Test Plan:
- len=3, A=[1,2,3], B=[4,5,6], zero-wait memory -> addresses A0,B0,A0+4,B0+4,A0+8,B0+8 in order; wb_data=32; wb_rd=op_rd; 14 cycles start->IDLE.
- len=0 -> no mem_req; wb_valid=1 with wb_data=0 in the second cycle.
- mem_gnt held low 3 cycles on first request -> mem_req/mem_addr stable throughout; result unchanged.
- A=[-2], B=[7], then A=[0x40000000], B=[4] -> wb_data=0xFFFFFFF2, then 0 (wrap).
- start pulsed during WAIT_B, and wb_ready low 2 cycles in WB -> second start ignored; wb_valid/wb_data held; busy high throughout.
- rst asserted in WAIT_A, then stray mem_rvalid -> all outputs 0 immediately; no wb_valid; next start computes correctly.
